// File: rtl/sha_round_ctrl.sv
// SHA-256 block controller: sequences the 64 rounds of an external datapath,
// owns the chaining value H and performs the per-word feed-forward add.
module sha_round_ctrl #(
  parameter int BLK_SIZE   = 256,
  parameter int WRD_SIZE   = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic                i_init,
  input  logic                i_msg_valid,
  input  logic [BLK_SIZE-1:0] i_round_hash,
  output logic                o_ready,
  output logic                o_round_en,
  output logic [5:0]          o_round_idx,
  output logic [BLK_SIZE-1:0] o_pre_blck_hash,
  output logic [BLK_SIZE-1:0] o_digest,
  output logic                o_done
);

  localparam int NW = BLK_SIZE / WRD_SIZE;
  localparam logic [255:0] SHA256_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [BLK_SIZE-1:0] IV = BLK_SIZE'(SHA256_IV);
  localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

  state_t              state;
  logic [BLK_SIZE-1:0] h;
  logic [BLK_SIZE-1:0] sum;

  // Feed-forward add: each word wraps on its own, no carry across lanes.
  for (genvar w = 0; w < NW; w++) begin : g_add
    assign sum[w*WRD_SIZE +: WRD_SIZE] = h[w*WRD_SIZE +: WRD_SIZE] + i_round_hash[w*WRD_SIZE +: WRD_SIZE];
  end

  assign o_round_en      = (state == ROUND) && i_msg_valid;
  assign o_pre_blck_hash = (state == ROUND && o_round_idx == 6'd0) ? h : i_round_hash;
  assign o_digest        = h;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      o_round_idx <= 6'd0;
      h           <= IV;
      o_done      <= 1'b0;
      o_ready     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state       <= ROUND;
            o_round_idx <= 6'd0;
            o_ready     <= 1'b0;
            if (i_init) h <= IV;
          end
        end
        ROUND: begin
          if (i_msg_valid) begin
            if (o_round_idx == LAST) begin
              o_round_idx <= 6'd0;
              state       <= ADD;
            end else begin
              o_round_idx <= o_round_idx + 6'd1;
            end
          end
        end
        ADD: begin
          h      <= sum;
          o_done <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          o_done  <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Bench for sha_round_ctrl: behavioural SHA-256 round datapath and schedule
// around the controller, with a scoreboard of expected digests and latencies.
module tb_sha_round_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_start, i_init, i_msg_valid;
  logic [255:0] round_hash;
  logic         o_ready, o_round_en, o_done;
  logic [5:0]   o_round_idx;
  logic [255:0] o_pre_blck_hash, o_digest;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sha_round_ctrl #(.BLK_SIZE(256), .WRD_SIZE(32), .NUM_ROUNDS(64)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_init(i_init),
    .i_msg_valid(i_msg_valid), .i_round_hash(round_hash), .o_ready(o_ready),
    .o_round_en(o_round_en), .o_round_idx(o_round_idx),
    .o_pre_blck_hash(o_pre_blck_hash), .o_digest(o_digest), .o_done(o_done)
  );

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M1_BLK = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2_BLK = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [31:0]  wsch [64];
  logic [255:0] dp;
  bit           ovr = 1'b0;

  typedef struct {
    logic [255:0] dig;
    bit           chk;
    int           lat;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_rnd(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    {a, b, c, d, e, f, g, hh} = s;
    t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Round datapath model: registered state, advances only on o_round_en.
  always @(posedge clk)
    if (o_round_en) dp <= sha_rnd(o_pre_blck_hash, KT[o_round_idx], wsch[o_round_idx]);

  assign round_hash = ovr ? {8{32'hffffffff}} : dp;

  task automatic load_block(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wsch[t] = blk[511 - 32*t -: 32];
      else begin
        s0 = ror(wsch[t-15], 7) ^ ror(wsch[t-15], 18) ^ (wsch[t-15] >> 3);
        s1 = ror(wsch[t-2], 17) ^ ror(wsch[t-2], 19) ^ (wsch[t-2] >> 10);
        wsch[t] = s1 + wsch[t-7] + s0 + wsch[t-16];
      end
    end
  endtask

  // Runs one block from IDLE (entered at a negedge) and reports what it saw.
  task automatic drive_block(input bit init, input int stall_at, input int stall_len,
                             input int pulse_at, input bit pulse_done,
                             output int lat, output logic [255:0] dig, output int ndone,
                             output int busy, output int stall_seen, output int stall_bad,
                             output int ready_at_pulse, output logic [255:0] dig_after);
    bit pulsed = 1'b0;
    lat = 0; ndone = 0; busy = 0; stall_seen = 0; stall_bad = 0; ready_at_pulse = -1;
    dig = '0;
    i_start = 1'b1; i_init = init; i_msg_valid = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    lat = 1;
    while (lat < 200 && !o_done) begin
      i_start = 1'b0;
      i_msg_valid = 1'b1;
      if (stall_at >= 0 && int'(o_round_idx) == stall_at && stall_seen < stall_len) begin
        i_msg_valid = 1'b0;
        stall_seen++;
        #1;
        if (int'(o_round_idx) != stall_at || o_round_en !== 1'b0) stall_bad++;
      end
      if (pulse_at >= 0 && int'(o_round_idx) == pulse_at && !pulsed) begin
        i_start = 1'b1;
        pulsed = 1'b1;
        ready_at_pulse = int'(o_ready);
      end
      @(negedge clk);
      lat++;
    end
    i_msg_valid = 1'b1;
    if (o_done) begin
      ndone = 1;
      dig = o_digest;
    end
    if (pulse_done) i_start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) ndone++;
      if (!o_ready) busy++;
    end
    dig_after = o_digest;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_start = 1'b1; i_init = 1'b0; i_msg_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1; i_start = 1'b0;
    total += 5;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    if (o_round_en !== 1'b0) begin bad++; $display("FAIL reset_round_en: got %b want 0", o_round_en); end
    if (o_round_idx !== 6'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", o_round_idx); end
    if (o_digest !== IV) begin bad++; $display("FAIL reset_digest: got %h want %h", o_digest, IV); end
  endtask

  task automatic test_abc();
    int lat, nd, busy, ss, sbad, rp; logic [255:0] dig, dga; exp_t e;
    load_block(ABC_BLK);
    sb.push_back('{ABC_DIG, 1'b1, 66});
    drive_block(1'b1, -1, 0, -1, 1'b0, lat, dig, nd, busy, ss, sbad, rp, dga);
    e = sb.pop_front();
    total += 5;
    if (lat != e.lat) begin bad++; $display("FAIL abc_latency: got %0d want %0d", lat, e.lat); end
    if (dig !== e.dig) begin bad++; $display("FAIL abc_digest: got %h want %h", dig, e.dig); end
    if (nd != 1) begin bad++; $display("FAIL abc_done_pulses: got %0d want 1", nd); end
    if (busy != 0) begin bad++; $display("FAIL abc_ready_after: got %0d busy cycles want 0", busy); end
    if (dga !== e.dig) begin bad++; $display("FAIL abc_digest_stable: got %h want %h", dga, e.dig); end
  endtask

  task automatic test_stall();
    int lat, nd, busy, ss, sbad, rp; logic [255:0] dig, dga; exp_t e;
    load_block(ABC_BLK);
    sb.push_back('{ABC_DIG, 1'b1, 71});
    drive_block(1'b1, 10, 5, -1, 1'b0, lat, dig, nd, busy, ss, sbad, rp, dga);
    e = sb.pop_front();
    total += 4;
    if (lat != e.lat) begin bad++; $display("FAIL stall_latency: got %0d want %0d", lat, e.lat); end
    if (dig !== e.dig) begin bad++; $display("FAIL stall_digest: got %h want %h", dig, e.dig); end
    if (ss != 5) begin bad++; $display("FAIL stall_cycles: got %0d want 5", ss); end
    if (sbad != 0) begin bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", sbad); end
  endtask

  task automatic test_ignore_start();
    int lat, nd, busy, ss, sbad, rp; logic [255:0] dig, dga; exp_t e;
    load_block(ABC_BLK);
    sb.push_back('{ABC_DIG, 1'b1, 66});
    drive_block(1'b1, -1, 0, 20, 1'b1, lat, dig, nd, busy, ss, sbad, rp, dga);
    e = sb.pop_front();
    total += 5;
    if (lat != e.lat) begin bad++; $display("FAIL ign_latency: got %0d want %0d", lat, e.lat); end
    if (dig !== e.dig) begin bad++; $display("FAIL ign_digest: got %h want %h", dig, e.dig); end
    if (rp != 0) begin bad++; $display("FAIL ign_ready_in_round: got %0d want 0", rp); end
    if (nd != 1) begin bad++; $display("FAIL ign_done_pulses: got %0d want 1", nd); end
    if (busy != 0) begin bad++; $display("FAIL ign_no_restart: got %0d busy cycles want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n = 0, dn = 0, busy = 0;
    load_block(ABC_BLK);
    i_start = 1'b1; i_init = 1'b0; i_msg_valid = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (o_round_idx != 6'd30 && n < 100) begin @(negedge clk); n++; end
    total += 1;
    if (o_round_idx != 6'd30) begin bad++; $display("FAIL rmid_reach_idx30: got %0d want 30", o_round_idx); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total += 5;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", o_ready); end
    if (o_round_idx !== 6'd0) begin bad++; $display("FAIL rmid_idx: got %0d want 0", o_round_idx); end
    if (o_digest !== IV) begin bad++; $display("FAIL rmid_digest: got %h want %h", o_digest, IV); end
    if (o_done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", o_done); end
    if (o_round_en !== 1'b0) begin bad++; $display("FAIL rmid_round_en: got %b want 0", o_round_en); end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (o_done) dn++;
      if (!o_ready) busy++;
    end
    total += 2;
    if (dn != 0) begin bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", dn); end
    if (busy != 0) begin bad++; $display("FAIL rmid_stays_idle: got %0d busy cycles want 0", busy); end
  endtask

  task automatic test_two_block();
    int lat, nd, busy, ss, sbad, rp; logic [255:0] dig, dga; exp_t e;
    load_block(M1_BLK);
    sb.push_back('{256'h0, 1'b0, 66});
    drive_block(1'b1, -1, 0, -1, 1'b0, lat, dig, nd, busy, ss, sbad, rp, dga);
    e = sb.pop_front();
    total += 1;
    if (lat != e.lat) begin bad++; $display("FAIL blk1_latency: got %0d want %0d", lat, e.lat); end
    load_block(M2_BLK);
    sb.push_back('{TWO_DIG, 1'b1, 66});
    drive_block(1'b0, -1, 0, -1, 1'b0, lat, dig, nd, busy, ss, sbad, rp, dga);
    e = sb.pop_front();
    total += 2;
    if (lat != e.lat) begin bad++; $display("FAIL blk2_latency: got %0d want %0d", lat, e.lat); end
    if (e.chk && dig !== e.dig) begin bad++; $display("FAIL two_block_digest: got %h want %h", dig, e.dig); end
  endtask

  task automatic test_word_wrap();
    int lat, nd, busy, ss, sbad, rp; logic [255:0] dig, dga, ex; exp_t e;
    ovr = 1'b1;
    ex = IV;
    for (int w = 0; w < 8; w++) ex[w*32 +: 32] = ex[w*32 +: 32] + 32'hffffffff;
    sb.push_back('{ex, 1'b1, 66});
    for (int w = 0; w < 8; w++) ex[w*32 +: 32] = ex[w*32 +: 32] + 32'hffffffff;
    sb.push_back('{ex, 1'b1, 66});
    drive_block(1'b1, -1, 0, -1, 1'b0, lat, dig, nd, busy, ss, sbad, rp, dga);
    e = sb.pop_front();
    total += 1;
    if (dig !== e.dig) begin bad++; $display("FAIL wrap_digest1: got %h want %h", dig, e.dig); end
    drive_block(1'b0, -1, 0, -1, 1'b0, lat, dig, nd, busy, ss, sbad, rp, dga);
    e = sb.pop_front();
    total += 1;
    if (dig !== e.dig) begin bad++; $display("FAIL wrap_digest2: got %h want %h", dig, e.dig); end
    ovr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; i_start = 1'b0; i_init = 1'b0; i_msg_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_abc();
    test_stall();
    test_ignore_start();
    test_reset_mid();
    test_two_block();
    test_word_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_round_ctrl.md
SHA_ROUND_CTRL -- requirements
Module: sha_round_ctrl

Interface
REQ-001 SHALL have parameter BLK_SIZE, default 256, hash state width in bits.
REQ-002 SHALL have parameter WRD_SIZE, default 32, word width in bits.
REQ-003 SHALL have parameter NUM_ROUNDS, default 64, rounds per block.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_start  input  1  request to hash one message block.
REQ-007 SHALL have port i_init  input  1  sampled with an accepted i_start; 1 = first block of a message.
REQ-008 SHALL have port i_msg_valid  input  1  message-schedule word for the current round is available.
REQ-009 SHALL have port i_round_hash  input  BLK_SIZE  registered state from the round datapath.
REQ-010 SHALL have port o_ready  output  1  controller idle; i_start is accepted.
REQ-011 SHALL have port o_round_en  output  1  enable to the round datapath; also the schedule-word consume strobe.
REQ-012 SHALL have port o_round_idx  output  6  round index; K-ROM address and schedule index.
REQ-013 SHALL have port o_pre_blck_hash  output  BLK_SIZE  state input to the round datapath.
REQ-014 SHALL have port o_digest  output  BLK_SIZE  chaining value register H.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse when o_digest holds the updated value.

Function
REQ-016 SHALL implement the FSM states IDLE, ROUND, ADD and DONE.
REQ-017 IDLE: o_ready=1; i_start=1 SHALL move the FSM to ROUND, clear o_round_idx to 0, and load H with the SHA-256 IV if i_init=1 (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, MSW first), else retain H.
REQ-018 ROUND: o_round_en SHALL equal i_msg_valid combinationally; a cycle with o_round_en=1 SHALL increment o_round_idx.
REQ-019 ROUND with o_round_idx=NUM_ROUNDS-1 and o_round_en=1 SHALL move the FSM to ADD; o_round_idx SHALL wrap to 0.
REQ-020 ROUND with i_msg_valid=0 SHALL stall: o_round_idx held, o_round_en=0; the datapath holds its state.
REQ-021 o_pre_blck_hash SHALL be H when o_round_idx=0 in ROUND, and i_round_hash otherwise.
REQ-022 ADD: H SHALL be updated to H + i_round_hash, per 32-bit word modulo 2^32, with no carry between words; o_round_en=0; the FSM SHALL move to DONE.
REQ-023 DONE: o_done=1 for exactly one cycle; the FSM SHALL move to IDLE.
REQ-024 o_ready SHALL be 1 only in IDLE; i_start outside IDLE SHALL be ignored and not queued.
REQ-025 With no stalls, o_done SHALL assert exactly NUM_ROUNDS+2 cycles after the cycle in which i_start is accepted; each stall cycle SHALL add one cycle.
REQ-026 o_digest SHALL change only in the start cycle (i_init=1) and in ADD; it SHALL remain stable between blocks so the next block chains from it (i_init=0).

Reset
REQ-027 reset_n=0 at a rising edge SHALL, in any state including mid-ROUND, force IDLE and set o_round_idx=0, H=IV, o_done=0, o_round_en=0 and o_ready=1 from the next cycle.
REQ-028 reset_n SHALL take priority over i_start in the same cycle.

Verification
REQ-029 Single block "abc" (padded, i_init=1, i_msg_valid=1): o_digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad with o_done exactly 66 cycles after start.
REQ-030 Stall: i_msg_valid=0 for 5 cycles at o_round_idx=10 -> o_round_idx holds at 10, o_round_en=0, o_done at 71 cycles, digest unchanged from REQ-029.
REQ-031 i_start pulsed at o_round_idx=20 and again in the DONE cycle -> both ignored, o_ready=0, single o_done, no restart.
REQ-032 reset_n=0 for one cycle at o_round_idx=30 -> next cycle IDLE, o_ready=1, o_round_idx=0, o_digest=IV, no o_done.
REQ-033 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (second block i_init=0) -> o_digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-034 A word-sum test with i_round_hash words at ffffffff in ADD -> each H word wraps modulo 2^32 with no carry into the adjacent word.
